// File: rtl/trans_packetizer_if.sv
// Stream bundle between the transmit-port source / DDS sink and the packetizer.
// Latency: none, wires only.
// Backpressure: input side has none; output side uses valid/ready.
interface trans_packetizer_if;
  logic        in_valid;
  logic        in_sof;
  logic [7:0]  in_data0;
  logic [7:0]  in_data1;
  logic [7:0]  in_data2;
  logic [7:0]  in_data3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        overflow;
  logic        clear_ovf;
  logic [15:0] pkt_count;

  // Environment side: drives input words, ready and overflow clear.
  modport master (
    output in_valid, in_sof, in_data0, in_data1, in_data2, in_data3,
    output out_ready, clear_ovf,
    input  out_valid, out_data, out_sop, out_eop, overflow, pkt_count
  );

  // Packetizer side.
  modport slave (
    input  in_valid, in_sof, in_data0, in_data1, in_data2, in_data3,
    input  out_ready, clear_ovf,
    output out_valid, out_data, out_sop, out_eop, overflow, pkt_count
  );
endinterface

// File: rtl/trans_packetizer.sv
// Buffers 4-lane transmit words and emits PRE0/PRE1/HDR/payload/CRC packets.
// Latency: out_valid rises one cycle after the FIFO count reaches PAYLOAD_WORDS.
// Backpressure: out_ready stalls the packet with outputs held; input is never stalled, excess words are dropped.
module trans_packetizer #(
  parameter int         PAYLOAD_WORDS = 16,
  parameter int         FIFO_DEPTH    = 64,
  parameter logic [7:0] PRE0_BYTE     = 8'hA5,
  parameter logic [7:0] PRE1_BYTE     = 8'h5A
) (
  input logic               clk,
  input logic               rstn,
  trans_packetizer_if.slave bus
);

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   PW_C     = CW'(PAYLOAD_WORDS);
  localparam logic [7:0]      PW_BYTE  = 8'(PAYLOAD_WORDS);
  localparam logic [7:0]      PAY_LAST = 8'(PAYLOAD_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE0,
    S_PRE1,
    S_HDR,
    S_PAY,
    S_CRC
  } state_t;

  // One CRC-8 step over a whole byte: poly 0x07, MSB first, no reflection.
  function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int k = 0; k < 8; k++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  state_t            state;
  state_t            state_nxt;

  logic [32:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [32:0]       head;
  logic              push;
  logic              pop;

  logic [7:0]        seq_q;
  logic [3:0][7:0]   crc_q;
  logic [7:0]        pay_cnt;
  logic [15:0]       pkt_cnt_q;
  logic              ovf_q;

  logic              out_valid_w;
  logic [31:0]       out_data_w;
  logic              out_sop_w;
  logic              out_eop_w;
  logic              xfer;

  // The head word is read combinationally so the FIFO falls through.
  assign head = mem[rd_ptr];
  assign xfer = out_valid_w & bus.out_ready;
  assign pop  = xfer && (state == S_PAY);
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push = bus.in_valid && ((count < DEPTH_C) || pop);

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, {sof, lane3, lane2, lane1, lane0}; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_sof, bus.in_data3, bus.in_data2, bus.in_data1, bus.in_data0};
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid && !push) begin
      ovf_q <= 1'b1;
    end else if (bus.clear_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  // Packet state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and output word; everything advances only on a transfer.
  always_comb begin
    state_nxt   = state;
    out_valid_w = 1'b0;
    out_data_w  = '0;
    out_sop_w   = 1'b0;
    out_eop_w   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (count >= PW_C) state_nxt = S_PRE0;
      end
      S_PRE0: begin
        out_valid_w = 1'b1;
        out_data_w  = {4{PRE0_BYTE}};
        out_sop_w   = 1'b1;
        if (bus.out_ready) state_nxt = S_PRE1;
      end
      S_PRE1: begin
        out_valid_w = 1'b1;
        out_data_w  = {4{PRE1_BYTE}};
        if (bus.out_ready) state_nxt = S_HDR;
      end
      S_HDR: begin
        out_valid_w = 1'b1;
        out_data_w  = {8'h00, PW_BYTE, seq_q, 7'd0, head[32]};
        if (bus.out_ready) state_nxt = S_PAY;
      end
      S_PAY: begin
        out_valid_w = 1'b1;
        out_data_w  = head[31:0];
        if (bus.out_ready && (pay_cnt == PAY_LAST)) state_nxt = S_CRC;
      end
      S_CRC: begin
        out_valid_w = 1'b1;
        out_data_w  = {crc_q[3], crc_q[2], crc_q[1], crc_q[0]};
        out_eop_w   = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequence number, lane CRCs, payload index and sent-packet counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seq_q     <= '0;
      crc_q     <= '0;
      pay_cnt   <= '0;
      pkt_cnt_q <= '0;
    end else if (xfer) begin
      case (state)
        S_HDR: begin
          crc_q   <= '0;
          pay_cnt <= '0;
        end
        S_PAY: begin
          for (int i = 0; i < 4; i++) begin
            crc_q[i] <= crc8_upd(crc_q[i], head[8*i +: 8]);
          end
          pay_cnt <= pay_cnt + 1'b1;
        end
        S_CRC: begin
          seq_q     <= seq_q + 8'd1;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_data_w;
  assign bus.out_sop   = out_sop_w;
  assign bus.out_eop   = out_eop_w;
  assign bus.overflow  = ovf_q;
  assign bus.pkt_count = pkt_cnt_q;

endmodule

// File: tb/tb_trans_packetizer.sv
// Testbench for trans_packetizer against a queue-based packet model.
// Latency: one step per clock; inputs driven and outputs sampled at the falling edge.
// Backpressure: out_ready is driven directed or random by the bench.
module tb_trans_packetizer;
  localparam int PW = 9;
  localparam int FD = 16;

  typedef struct packed {
    logic        sof;
    logic [31:0] dat;
  } word_t;

  logic clk;
  logic rstn;
  trans_packetizer_if tb_if ();

  trans_packetizer #(
    .PAYLOAD_WORDS (PW),
    .FIFO_DEPTH    (FD),
    .PRE0_BYTE     (8'hA5),
    .PRE1_BYTE     (8'h5A)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (tb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state.
  word_t       mq[$];
  logic [31:0] m_pay[$];
  logic [31:0] got[$];
  bit          m_busy;
  int          m_pos;
  logic [7:0]  m_seq;
  logic [15:0] m_pkt;
  logic        m_ovf;
  bit          hold_vld;
  logic [31:0] hold_dat;
  logic        hold_sop;
  logic        hold_eop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input int lane);
    logic [7:0] c;
    logic [7:0] b;
    logic       fb;
    c = 8'h00;
    foreach (m_pay[i]) begin
      b = m_pay[i][8*lane +: 8];
      for (int k = 7; k >= 0; k--) begin
        fb = c[7] ^ b[k];
        c  = {c[6:0], 1'b0};
        if (fb) c = c ^ 8'h07;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] got_at(input int i);
    if (got.size() > i) return got[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pay.delete();
    got.delete();
    m_busy   = 0;
    m_pos    = 0;
    m_seq    = 8'h00;
    m_pkt    = 16'h0000;
    m_ovf    = 1'b0;
    hold_vld = 0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic vld, input logic sof, input logic [31:0] d, input logic clr);
    logic        xfer, pop, acc, last;
    logic [31:0] ew;
    logic        es, ee;
    int          cnt_now;
    tb_if.in_valid  = vld;
    tb_if.in_sof    = sof;
    tb_if.in_data0  = d[7:0];
    tb_if.in_data1  = d[15:8];
    tb_if.in_data2  = d[23:16];
    tb_if.in_data3  = d[31:24];
    tb_if.clear_ovf = clr;
    #1;
    chk("out_valid", 32'(tb_if.out_valid), 32'(m_busy));
    chk("overflow", 32'(tb_if.overflow), 32'(m_ovf));
    chk("pkt_count", 32'(tb_if.pkt_count), 32'(m_pkt));
    if (hold_vld) begin
      chk("hold_data", tb_if.out_data, hold_dat);
      chk("hold_sop", 32'(tb_if.out_sop), 32'(hold_sop));
      chk("hold_eop", 32'(tb_if.out_eop), 32'(hold_eop));
    end
    hold_vld = tb_if.out_valid && !tb_if.out_ready;
    hold_dat = tb_if.out_data;
    hold_sop = tb_if.out_sop;
    hold_eop = tb_if.out_eop;
    xfer    = tb_if.out_valid && tb_if.out_ready;
    pop     = 1'b0;
    last    = 1'b0;
    cnt_now = mq.size();
    if (xfer) begin
      es = 1'b0;
      ee = 1'b0;
      ew = 32'h0;
      if (m_pos == 0) begin
        ew = 32'hA5A5A5A5;
        es = 1'b1;
        got.delete();
      end else if (m_pos == 1) begin
        ew = 32'h5A5A5A5A;
      end else if (m_pos == 2) begin
        ew = {8'h00, 8'(PW), m_seq, 7'd0, (mq.size() > 0) ? mq[0].sof : 1'b0};
        m_pay.delete();
      end else if (m_pos < PW + 3) begin
        if (mq.size() > 0) begin
          ew = mq[0].dat;
          m_pay.push_back(mq[0].dat);
          void'(mq.pop_front());
        end else begin
          ew = 32'hxxxx_xxxx;
        end
        pop = 1'b1;
      end else begin
        ew   = {ref_crc(3), ref_crc(2), ref_crc(1), ref_crc(0)};
        ee   = 1'b1;
        last = 1'b1;
        m_seq = m_seq + 8'd1;
        m_pkt = m_pkt + 16'd1;
      end
      got.push_back(tb_if.out_data);
      chk($sformatf("data_pos%0d", m_pos), tb_if.out_data, ew);
      chk($sformatf("sop_pos%0d", m_pos), 32'(tb_if.out_sop), 32'(es));
      chk($sformatf("eop_pos%0d", m_pos), 32'(tb_if.out_eop), 32'(ee));
      m_pos = last ? 0 : m_pos + 1;
    end
    if (m_busy) m_busy = !last;
    else        m_busy = (cnt_now >= PW);
    acc = vld && ((cnt_now < FD) || pop);
    if (acc) mq.push_back('{sof: sof, dat: d});
    if (vld && !acc) m_ovf = 1'b1;
    else if (clr)    m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int i;
    tb_if.out_ready = 1'b1;
    for (i = 0; i < 400; i++) begin
      if (!m_busy && mq.size() < PW) break;
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("drain_bound", 32'(i < 400), 32'd1);
  endtask

  task automatic topup();
    int n;
    n = (PW - (mq.size() % PW)) % PW;
    tb_if.out_ready = 1'b1;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, $urandom(), 1'b0);
    drain();
  endtask

  initial begin
    int i;
    rstn            = 1'b1;
    tb_if.in_valid  = 1'b0;
    tb_if.in_sof    = 1'b0;
    tb_if.in_data0  = 8'h0;
    tb_if.in_data1  = 8'h0;
    tb_if.in_data2  = 8'h0;
    tb_if.in_data3  = 8'h0;
    tb_if.out_ready = 1'b0;
    tb_if.clear_ovf = 1'b0;
    model_reset();

    // Reset values.
    #3 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(tb_if.out_valid), 32'd0);
    chk("rst_out_sop", 32'(tb_if.out_sop), 32'd0);
    chk("rst_out_eop", 32'(tb_if.out_eop), 32'd0);
    chk("rst_out_data", tb_if.out_data, 32'd0);
    chk("rst_overflow", 32'(tb_if.overflow), 32'd0);
    chk("rst_pkt_count", 32'(tb_if.pkt_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Scenario 1: "123456789" on lane 0, sof on first word.
    tb_if.out_ready = 1'b1;
    for (int k = 0; k < PW; k++) step(1'b1, 1'(k == 0), 32'h31 + 32'(k), 1'b0);
    drain();
    chk("s1_len", 32'(got.size()), 32'd13);
    chk("s1_pre0", got_at(0), 32'hA5A5A5A5);
    chk("s1_pre1", got_at(1), 32'h5A5A5A5A);
    chk("s1_hdr", got_at(2), 32'h00090001);
    chk("s1_crc", got_at(12), 32'h000000F4);
    chk("s1_pkt_count", 32'(tb_if.pkt_count), 32'd1);

    // Scenario 2: random payload, no sof.
    for (int k = 0; k < PW; k++) step(1'b1, 1'b0, $urandom(), 1'b0);
    drain();
    chk("s2_hdr", got_at(2), 32'h00090100);
    chk("s2_pkt_count", 32'(tb_if.pkt_count), 32'd2);

    // Scenario 3: same payload as scenario 1 under random ready and a long stall.
    for (int k = 0; k < PW; k++) step(1'b1, 1'(k == 0), 32'h31 + 32'(k), 1'b0);
    for (i = 0; i < 200 && m_pos != 5; i++) begin
      tb_if.out_ready = 1'($urandom_range(0, 1));
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("s3_reach_pay", 32'(m_pos), 32'd5);
    tb_if.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    for (i = 0; i < 300 && (m_busy || mq.size() >= PW); i++) begin
      tb_if.out_ready = 1'($urandom_range(0, 1));
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("s3_bound", 32'(i < 300), 32'd1);
    chk("s3_hdr", got_at(2), 32'h00090201);
    chk("s3_crc", got_at(12), 32'h000000F4);
    chk("s3_pkt_count", 32'(tb_if.pkt_count), 32'd3);

    // Random traffic: writes during packet output, random ready and clears.
    for (int k = 0; k < 250; k++) begin
      tb_if.out_ready = 1'($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), $urandom(),
           1'($urandom_range(0, 15) == 0));
    end
    drain();
    topup();
    step(1'b0, 1'b0, 32'h0, 1'b1);

    // Scenario 4: stalled output, 20 writes into a 16-deep FIFO.
    tb_if.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 32'h1000 + 32'(k), 1'b0);
    chk("s4_overflow_set", 32'(tb_if.overflow), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("s4_overflow_clr", 32'(tb_if.overflow), 32'd0);

    // Scenario 5: full FIFO, write on the cycle of a payload pop.
    tb_if.out_ready = 1'b1;
    for (i = 0; i < 10 && m_pos != 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("s5_reach_pay", 32'(m_pos), 32'd3);
    step(1'b1, 1'b0, 32'hCAFE0017, 1'b0);
    chk("s5_no_overflow", 32'(tb_if.overflow), 32'd0);
    drain();
    topup();

    // Scenario 6: reset in the middle of the payload.
    for (int k = 0; k < PW; k++) step(1'b1, 1'b0, $urandom(), 1'b0);
    for (i = 0; i < 20 && m_pos != 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("s6_reach_pay", 32'(m_pos), 32'd6);
    tb_if.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("s6_rst_valid", 32'(tb_if.out_valid), 32'd0);
    chk("s6_rst_data", tb_if.out_data, 32'd0);
    chk("s6_rst_sop", 32'(tb_if.out_sop), 32'd0);
    chk("s6_rst_eop", 32'(tb_if.out_eop), 32'd0);
    chk("s6_rst_pkt_count", 32'(tb_if.pkt_count), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < PW; k++) step(1'b1, 1'b0, $urandom(), 1'b0);
    drain();
    chk("s6_len", 32'(got.size()), 32'd13);
    chk("s6_hdr", got_at(2), 32'h00090000);
    chk("s6_pkt_count", 32'(tb_if.pkt_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/trans_packetizer.md
Name: trans_packetizer

Overview:
Sits between the slant-memory transmit port (TransValid plus four 8-bit lanes) and the DDS controller. It buffers incoming 4-lane words in a FIFO and emits fixed-length packets over a 32-bit valid/ready stream. Each packet carries a preamble, a header with sequence number and start-of-frame flag, the payload, and a per-lane CRC-8 trailer. The receiver side uses these to regain word alignment and detect lane errors.

Parameters:
PAYLOAD_WORDS, 16, number of 32-bit payload words per packet; range 2..255.
FIFO_DEPTH, 64, input FIFO depth in words; power of 2, at least PAYLOAD_WORDS.
PRE0_BYTE, 8'hA5, byte replicated on all lanes in preamble word 0.
PRE1_BYTE, 8'h5A, byte replicated on all lanes in preamble word 1.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  input word strobe (TransValid); no backpressure
in_sof  in  1  word is the first of a video frame; sampled with in_valid
in_data0  in  8  lane 0 byte (Trans0Data)
in_data1  in  8  lane 1 byte
in_data2  in  8  lane 2 byte
in_data3  in  8  lane 3 byte
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts word
out_data  out  32  {lane3,lane2,lane1,lane0}
out_sop  out  1  first word of packet (PRE0)
out_eop  out  1  last word of packet (CRC)
overflow  out  1  sticky: an input word was dropped
clear_ovf  in  1  synchronous clear of overflow
pkt_count  out  16  packets fully sent, wraps at 0xFFFF

Behaviour:
- Reset (asynchronous, rstn=0):
  - FIFO emptied; state=IDLE; seq=0; CRCs=0.
  - out_valid=0, out_sop=0, out_eop=0, out_data=0, overflow=0, pkt_count=0.
  - Reset asserted mid-packet abandons the packet; nothing resumes after release.
- FIFO:
  - 33 bits wide: {sof, data}; first-word-fall-through; occupancy count kept in a register.
  - Write when in_valid=1 and either (count < FIFO_DEPTH) or a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set.
  - If set and clear at the same cycle, set wins.
- Handshake:
  - A word transfers when out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_data, out_sop and out_eop are held stable.
  - out_valid never drops without a transfer.
- FSM:
  - IDLE -> PRE0 when count >= PAYLOAD_WORDS. out_valid rises the cycle after the count condition is registered true.
  - PRE0: data = {4{PRE0_BYTE}}, sop=1. On transfer -> PRE1.
  - PRE1: data = {4{PRE1_BYTE}}. On transfer -> HDR.
  - HDR: data = {8'h00, PAYLOAD_WORDS[7:0], seq, flags}. flags bit0 = sof bit of the FIFO head word; other flag bits are 0. On transfer, clear all four lane CRCs to 0x00 and go -> PAY.
  - PAY: data = FIFO head data. Each transfer pops the FIFO and updates each lane CRC with that lane's byte. After PAYLOAD_WORDS transfers -> CRC. The FIFO is guaranteed non-empty in PAY because the count was checked at start.
  - CRC: data = {crc3, crc2, crc1, crc0}, eop=1. On transfer: seq += 1 (8-bit wrap), pkt_count += 1, then -> IDLE.
  - A new packet may start on the cycle after the CRC transfer if count >= PAYLOAD_WORDS.
- CRC-8 definition:
  - Polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR.
  - Computed bytewise in one cycle.
  - Check value: "123456789" -> 0xF4.
- Word count per packet is PAYLOAD_WORDS+4. Input writes continue during packet output.

Test Plan:
1. PAYLOAD_WORDS=9, out_ready=1. Lane0 bytes 0x31..0x39, lanes 1-3 zero, first word in_sof=1.
   -> Packet = A5A5A5A5, 5A5A5A5A, 0x00090001, 9 payload words, then CRC word 0x000000F4.
   -> sop on word 0, eop on word 12, pkt_count=1.
2. Continue with a second packet, in_sof=0 throughout.
   -> Header = 0x00090100 (seq=1), pkt_count=2.
3. out_ready toggled randomly, including held low for 20 cycles mid-PAY.
   -> out_data/sop/eop stable while stalled; payload order and CRC unchanged from scenario 1.
4. FIFO_DEPTH=16, out_ready=0, 20 input words.
   -> First 16 accepted, overflow=1. clear_ovf pulse -> 0.
   -> Release out_ready: only the 16 accepted words appear as payload.
5. Full FIFO with pop and in_valid in the same cycle.
   -> Word accepted, overflow stays 0.
6. Assert rstn=0 during PAY, then release with 9 new words written.
   -> Outputs 0 during reset; next packet starts at PRE0 with seq=0 and fresh CRCs.
